alu_op_sequencer_bf16: RTL

//   Initiator side of the alu_bf16 operand/opcode interface. Accepts one

---
 rtl/alu_op_sequencer_bf16_if.sv | 33 +++
 rtl/alu_op_sequencer_bf16.sv | 113 +++++++++++
 2 files changed

// File: rtl/alu_op_sequencer_bf16_if.sv
// Command, ALU-side and response signals of the bf16 ALU op sequencer.
// slave = sequencer view, master = issue/consumer/ALU environment view.
interface alu_op_sequencer_bf16_if #(
    parameter int WIDTH = 16
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [3:0]       cmd_op;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [3:0]       alu_ctrl;
    logic [WIDTH-1:0] alu_y;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_err;

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b,
        input  alu_y, rsp_ready,
        output cmd_ready, alu_a, alu_b, alu_ctrl,
        output rsp_valid, rsp_data, rsp_err
    );

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b,
        output alu_y, rsp_ready,
        input  cmd_ready, alu_a, alu_b, alu_ctrl,
        input  rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/alu_op_sequencer_bf16.sv
// Single-outstanding sequencer in front of the fixed-latency alu_bf16.
// Latches a command, waits ALU_LATENCY edges, returns alu_y as a response.
module alu_op_sequencer_bf16 #(
    parameter int WIDTH       = 16,
    parameter int ALU_LATENCY = 2,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 clock,
    input  logic                 reset_n,
    alu_op_sequencer_bf16_if.slave bus,
    output logic [CNT_WIDTH-1:0] op_count
);
    localparam int CW = (ALU_LATENCY > 0) ? $clog2(ALU_LATENCY + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] data_q;
    logic             err_q;
    logic [CW-1:0]    wait_cnt;
    logic             cmd_legal;
    logic             cmd_fire;
    logic             rsp_fire;

    assign cmd_legal = (bus.cmd_op == 4'd1) || (bus.cmd_op == 4'd2)
                     || (bus.cmd_op == 4'd3);
    assign cmd_fire  = (state == S_IDLE) && bus.cmd_valid;
    assign rsp_fire  = (state == S_DONE) && bus.rsp_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    state_nxt = cmd_legal ? S_WAIT : S_DONE;
                end
            end
            S_WAIT: begin
                if (wait_cnt == '0) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.rsp_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Illegal opcodes skip the ALU and leave alu_a/alu_b untouched.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            data_q   <= '0;
            err_q    <= 1'b0;
            wait_cnt <= '0;
            op_count <= '0;
        end else begin
            if (cmd_fire) begin
                if (cmd_legal) begin
                    op_q     <= bus.cmd_op;
                    a_q      <= bus.cmd_a;
                    b_q      <= bus.cmd_b;
                    wait_cnt <= CW'(ALU_LATENCY);
                end else begin
                    data_q <= '0;
                    err_q  <= 1'b1;
                end
            end
            if (state == S_WAIT) begin
                if (wait_cnt != '0) begin
                    wait_cnt <= wait_cnt - CW'(1);
                end else begin
                    data_q <= bus.alu_y;
                    err_q  <= 1'b0;
                end
            end
            if (rsp_fire) begin
                op_count <= op_count + CNT_WIDTH'(1);
            end
        end
    end

    always_comb begin
        bus.cmd_ready = (state == S_IDLE);
        bus.rsp_valid = (state == S_DONE);
        bus.alu_ctrl  = (state == S_WAIT) ? op_q : 4'd0;
        bus.alu_a     = a_q;
        bus.alu_b     = b_q;
        bus.rsp_data  = data_q;
        bus.rsp_err   = err_q;
    end
endmodule
